seq_detector_prog: RTL and testbench

- Runtime-programmable serial bit-pattern detector. Parametrised successor to the fixed 7-bit detector.
- Pattern, length (1..MAX_LEN) and overlap mode are loaded through a config port.
- Builds a full KMP transition table in hardware, one state per cycle, then scans a valid-qualified bit stream.
- Raises a registered match pulse and keeps a saturating match count. Sits between a serial deserialiser front end and the status/interrupt logic.

---
 rtl/seq_det_pkg.sv | 16 +
 rtl/seq_det_table_builder.sv | 84 ++++++++
 rtl/seq_detector_prog.sv | 106 ++++++++++
 tb/tb_seq_detector_prog.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and sizing helpers for the runtime-programmable serial pattern detector.
package seq_det_pkg;

  localparam int DEF_MAX_LEN = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUILD = 2'd1,
    ST_RUN   = 2'd2
  } fsm_e;

  function automatic int state_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/seq_det_table_builder.sv
// Builds the KMP next-state table one row per cycle and serves (state, bit) lookups.
module seq_det_table_builder
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LW      = state_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [MAX_LEN-1:0] pat_i,
  input  logic [LW-1:0]      len_i,
  output logic               done_o,
  input  logic [LW-1:0]      lk_st_i,
  input  logic               lk_bit_i,
  output logic [LW-1:0]      lk_nxt_o,
  output logic [LW-1:0]      border_o
);

  typedef struct packed {
    logic [LW-1:0] nxt0;
    logic [LW-1:0] nxt1;
  } row_t;

  row_t          tbl_q [MAX_LEN];
  logic          busy_q;
  logic [LW-1:0] s_q, x_q, border_q;
  row_t          row_d, xrow, lkrow;
  logic [LW-1:0] x_d;
  logic          p;

  // Selects are done by compare-loops so the LW-wide indices never overrun the arrays.
  always_comb begin
    p     = 1'b0;
    xrow  = '0;
    lkrow = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (s_q == LW'(i))     p     = pat_i[i];
      if (x_q == LW'(i))     xrow  = tbl_q[i];
      if (lk_st_i == LW'(i)) lkrow = tbl_q[i];
    end
  end

  // X trails s and always points at a row that is already complete.
  always_comb begin
    if (s_q == '0) begin
      row_d.nxt0 = p ? '0 : LW'(1);
      row_d.nxt1 = p ? LW'(1) : '0;
      x_d        = '0;
    end else begin
      row_d.nxt0 = p ? xrow.nxt0 : s_q + LW'(1);
      row_d.nxt1 = p ? s_q + LW'(1) : xrow.nxt1;
      x_d        = p ? xrow.nxt1 : xrow.nxt0;
    end
  end

  assign done_o   = busy_q && (s_q == len_i - LW'(1));
  assign lk_nxt_o = lk_bit_i ? lkrow.nxt1 : lkrow.nxt0;
  assign border_o = border_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q   <= 1'b0;
      s_q      <= '0;
      x_q      <= '0;
      border_q <= '0;
      for (int i = 0; i < MAX_LEN; i++) tbl_q[i] <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      s_q    <= '0;
      x_q    <= '0;
    end else if (busy_q) begin
      for (int i = 0; i < MAX_LEN; i++)
        if (s_q == LW'(i)) tbl_q[i] <= row_d;
      s_q <= s_q + LW'(1);
      x_q <= x_d;
      if (done_o) begin
        busy_q   <= 1'b0;
        border_q <= x_d;
      end
    end
  end

endmodule

// File: rtl/seq_detector_prog.sv
// Programmable serial bit-pattern detector: config FSM, KMP scan state, match pulse and
// saturating match counter.
module seq_detector_prog
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int CNT_W   = 8,
  parameter int LW      = state_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LW-1:0]      cfg_len,
  input  logic               cfg_overlap,
  output logic               cfg_busy,
  output logic               cfg_err,
  input  logic               in_valid,
  input  logic               in_data,
  output logic               in_ready,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  input  logic               clr_count
);

  fsm_e               fsm_q, fsm_d;
  logic [MAX_LEN-1:0] pat_q;
  logic [LW-1:0]      len_q, st_q, st_d;
  logic               ovl_q, match_q, err_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               len_ok, can_load, load_ok, accept, hit, bld_done;
  logic [LW-1:0]      lk_nxt, border;

  assign len_ok   = (cfg_len != '0) && (cfg_len <= LW'(MAX_LEN));
  assign can_load = cfg_load && (fsm_q != ST_BUILD);
  assign load_ok  = can_load && len_ok;
  assign cfg_busy = (fsm_q == ST_BUILD);
  assign in_ready = !cfg_busy;
  assign accept   = in_valid && in_ready;
  // A reload in the same cycle as an accepted bit wins; that bit is dropped.
  assign hit      = (fsm_q == ST_RUN) && accept && !load_ok && (lk_nxt == len_q);

  seq_det_table_builder #(.MAX_LEN(MAX_LEN), .LW(LW)) u_tbl (
    .clk      (clk),
    .rst      (rst),
    .start_i  (load_ok),
    .pat_i    (pat_q),
    .len_i    (len_q),
    .done_o   (bld_done),
    .lk_st_i  (st_q),
    .lk_bit_i (in_data),
    .lk_nxt_o (lk_nxt),
    .border_o (border)
  );

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      ST_IDLE:  if (load_ok)  fsm_d = ST_BUILD;
      ST_BUILD: if (bld_done) fsm_d = ST_RUN;
      ST_RUN:   if (load_ok)  fsm_d = ST_BUILD;
      default:  fsm_d = ST_IDLE;
    endcase

    st_d = st_q;
    if (load_ok)
      st_d = '0;
    else if ((fsm_q == ST_RUN) && accept)
      st_d = hit ? (ovl_q ? border : '0) : lk_nxt;

    cnt_d = cnt_q;
    if (clr_count)
      cnt_d = hit ? CNT_W'(1) : '0;
    else if (hit && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q   <= ST_IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b0;
      st_q    <= '0;
      match_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      st_q    <= st_d;
      match_q <= hit;
      err_q   <= can_load && !len_ok;
      cnt_q   <= cnt_d;
      if (load_ok) begin
        pat_q <= cfg_pattern;
        len_q <= cfg_len;
        ovl_q <= cfg_overlap;
      end
    end
  end

  assign match       = match_q;
  assign match_count = cnt_q;
  assign cfg_err     = err_q;

endmodule

// File: tb/tb_seq_detector_prog.sv
// Randomised self-checking bench; the reference compares the tail of the received bit
// history against the pattern instead of walking a transition table.
module tb_seq_detector_prog;

  localparam int MAX_LEN = 16;
  localparam int CNT_W   = 2;
  localparam int LW      = $clog2(MAX_LEN + 1);
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               cfg_load = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LW-1:0]      cfg_len = '0;
  logic               cfg_overlap = 1'b0;
  logic               cfg_busy, cfg_err, in_ready, match;
  logic               in_valid = 1'b0;
  logic               in_data = 1'b0;
  logic               clr_count = 1'b0;
  logic [CNT_W-1:0]   match_count;

  int errs = 0;
  int checks = 0;

  // reference model state
  logic [MAX_LEN-1:0] m_pat = '0;
  int                 m_len = 0;
  bit                 m_ovl = 1'b0;
  bit                 m_run = 1'b0;
  int                 m_cnt = 0;
  bit                 q[$];
  int                 hits = 0;

  always #5 clk = ~clk;

  seq_detector_prog #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cfg_busy    (cfg_busy),
    .cfg_err     (cfg_err),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .match       (match),
    .match_count (match_count),
    .clr_count   (clr_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // A match is the last m_len bits since the last restart point spelling the pattern.
  task automatic model_bit(input bit b, output bit hit);
    hit = 1'b0;
    q.push_back(b);
    if (q.size() > 2 * MAX_LEN) void'(q.pop_front());
    if (m_run && q.size() >= m_len) begin
      hit = 1'b1;
      for (int i = 0; i < m_len; i++)
        if (q[q.size() - m_len + i] != m_pat[i]) hit = 1'b0;
    end
    if (hit && !m_ovl) q.delete();
  endtask

  // Called at a negedge; outputs are checked at the following negedge.
  task automatic push(input bit v, input bit b, input bit clr);
    bit hit;
    hit = 1'b0;
    in_valid = v; in_data = b; clr_count = clr;
    if (v) model_bit(b, hit);
    if (clr) m_cnt = hit ? 1 : 0;
    else if (hit && m_cnt < CMAX) m_cnt++;
    @(negedge clk);
    in_valid = 1'b0; clr_count = 1'b0;
    check("match", match, hit);
    check("count", match_count, m_cnt);
    if (match) hits++;
  endtask

  task automatic stream(input logic [31:0] bits, input int n);
    logic [31:0] w;
    w = bits;
    for (int i = 0; i < n; i++) push(1'b1, w[i], 1'b0);
  endtask

  task automatic load(input logic [MAX_LEN-1:0] p, input int len, input bit ovl);
    bit ok;
    ok = (len >= 1) && (len <= MAX_LEN);
    cfg_load = 1'b1; cfg_pattern = p; cfg_len = LW'(len); cfg_overlap = ovl;
    @(negedge clk);
    cfg_load = 1'b0;
    check("cfg_err", cfg_err, !ok);
    if (ok) begin
      m_pat = p; m_len = len; m_ovl = ovl; m_run = 1'b1; q.delete();
      for (int i = 0; i < len; i++) begin
        check("busy", cfg_busy, 1);
        check("ready_bld", in_ready, 0);
        @(negedge clk);
      end
      check("busy_end", cfg_busy, 0);
    end else begin
      check("busy_bad", cfg_busy, 0);
      @(negedge clk);
      check("cfg_err_end", cfg_err, 0);
    end
  endtask

  initial begin
    logic [MAX_LEN-1:0] rp;
    int                 rl;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_match", match, 0);
    check("rst_count", match_count, 0);
    check("rst_busy", cfg_busy, 0);
    check("rst_err", cfg_err, 0);
    rst = 1'b1;
    @(negedge clk);
    check("idle_ready", in_ready, 1);

    hits = 0;
    stream(32'h0000_00FF, 8);
    check("idle_hits", hits, 0);

    load(16'b1010011, 7, 1'b0);
    hits = 0;
    stream(32'b1010011, 7);
    check("tp1_hits", hits, 1);
    check("tp1_cnt", match_count, 1);
    push(1'b0, 1'b0, 1'b0);

    load(16'b101, 3, 1'b1);
    hits = 0;
    stream(32'b10101, 5);
    check("ovl_hits", hits, 2);
    check("ovl_cnt", match_count, 3);

    load(16'b101, 3, 1'b0);
    hits = 0;
    stream(32'b10101, 5);
    check("novl_hits", hits, 1);

    load(16'b011, 3, 1'b0);
    hits = 0;
    stream(32'b0111, 4);
    check("kmp_hits", hits, 1);

    load(16'hFFFF, 0, 1'b1);
    load(16'h0000, 17, 1'b1);
    hits = 0;
    stream(32'b011, 3);
    check("keep_hits", hits, 1);

    push(1'b0, 1'b0, 1'b1);
    check("clr_cnt", match_count, 0);
    load(16'b1, 1, 1'b0);
    hits = 0;
    stream(32'b10111, 5);
    check("len1_hits", hits, 4);
    push(1'b1, 1'b1, 1'b0);
    check("sat_cnt", match_count, CMAX);
    push(1'b1, 1'b1, 1'b1);
    check("clr_inc_cnt", match_count, 1);

    // loads and bits offered during BUILD are ignored
    cfg_load = 1'b1; cfg_pattern = 16'b011; cfg_len = LW'(3); cfg_overlap = 1'b0;
    @(negedge clk);
    check("bld_busy1", cfg_busy, 1);
    cfg_pattern = 16'b111; cfg_len = '0; in_valid = 1'b1; in_data = 1'b1;
    check("bld_ready", in_ready, 0);
    @(negedge clk);
    cfg_load = 1'b0; in_valid = 1'b0;
    check("bld_noerr", cfg_err, 0);
    check("bld_busy2", cfg_busy, 1);
    @(negedge clk);
    check("bld_busy3", cfg_busy, 1);
    @(negedge clk);
    check("bld_busy_end", cfg_busy, 0);
    m_pat = 16'b011; m_len = 3; m_ovl = 1'b0; m_run = 1'b1; q.delete();
    hits = 0;
    stream(32'b01, 2);
    stream(32'b011, 3);
    check("bld_hits", hits, 1);

    for (int k = 0; k < 6; k++) begin
      rp = MAX_LEN'($urandom);
      rl = (k == 0) ? MAX_LEN : int'($urandom_range(1, 5));
      load(rp, rl, 1'($urandom));
      for (int n = 0; n < 150; n++)
        push($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 19) == 0);
    end

    // reset while a match pulse is high
    load(16'b11, 2, 1'b1);
    stream(32'b11, 2);
    rst = 1'b0;
    #1;
    check("rstm_match", match, 0);
    check("rstm_count", match_count, 0);
    check("rstm_busy", cfg_busy, 0);
    m_run = 1'b0; m_cnt = 0; q.delete();
    @(negedge clk);
    rst = 1'b1;
    hits = 0;
    stream(32'b1111, 4);
    check("rstm_hits", hits, 0);

    // reset in the middle of a build
    cfg_load = 1'b1; cfg_pattern = 16'b10110; cfg_len = LW'(5); cfg_overlap = 1'b0;
    @(negedge clk);
    cfg_load = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rstb_busy", cfg_busy, 0);
    @(negedge clk);
    rst = 1'b1;
    hits = 0;
    stream(32'b10110, 5);
    check("rstb_hits", hits, 0);
    load(16'b10110, 5, 1'b0);
    hits = 0;
    stream(32'b10110, 5);
    check("reload_hits", hits, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
